genaxis_descriptor_gen: RTL and testbench
=========================================

# genaxis_descriptor_gen

- Produces the packet descriptor stream `{channel, pause, length}` consumed by `genaxis_descriptor_to_axis`.
- Sits directly upstream of that block; driven by a register/config front end.
- Issues a configured number of descriptors (or runs until stopped):
  - lengths drawn pseudo-randomly in `[len_min, len_max]`;
  - fixed inter-packet pause;
  - channel ID rotating round-robin over a configured range.

## Interface

**Parameters**
- `ID_WIDTH`, default 10: channel field width; must match downstream.
- `LFSR_SEED`, default 16'hACE1: LFSR load value on reset and on every start. A value of 0 is replaced by 16'h0001.

**Ports**
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_start_i` in 1: pulse; starts a run when idle.
- `cfg_stop_i` in 1: pulse; aborts the run.
- `cfg_packet_count_i` in 32: descriptors per run; 0 = infinite.
- `cfg_len_min_i` in 16: minimum length, bytes.
- `cfg_len_max_i` in 16: maximum length, bytes.
- `cfg_pause_i` in 32: pause field, cycles.
- `cfg_channel_first_i` in ID_WIDTH: first channel of the rotation.
- `cfg_channel_last_i` in ID_WIDTH: last channel of the rotation.
- `out_descriptor_data_o` out 48+ID_WIDTH: `{channel, pause[31:0], length[15:0]}`.
- `out_descriptor_valid_o` out 1: descriptor valid.
- `out_descriptor_ready_i` in 1: downstream ready.
- `busy_o` out 1: run in progress.
- `done_o` out 1: one-cycle pulse on return to IDLE.
- `sent_count_o` out 32: descriptors accepted in the current/last run.

## Operation

**Config latch**
- All `cfg_*` values are latched on an accepted start and ignored for the rest of the run.
- Length clamps:
  - `len_min` = max(cfg_len_min, 1);
  - `len_max` = max(cfg_len_max, len_min).
- Channel range: if first > last, the rotation holds `first` only.

**FSM states: IDLE, GEN, OFFER**
- **IDLE**
  - `busy_o`=0.
  - `cfg_start_i`=1 with `cfg_stop_i`=0: latch config, reload LFSR with the seed, clear `sent_count_o`, channel = first, go to GEN.
  - Start and stop asserted in the same cycle: start is ignored.
- **GEN**
  - One LFSR step per cycle. Candidate = `lfsr & mask`.
  - `mask` = OR-smear of `range` = `len_max - len_min`, i.e. the smallest 2^k-1 ≥ range.
  - Candidate ≤ range: register data `{channel, pause, len_min + candidate}`, set valid, go to OFFER.
  - Candidate > range: rejected; stay in GEN.
  - `cfg_stop_i` in GEN: go to IDLE immediately, no descriptor issued.
- **OFFER**
  - Valid is held and data is stable until the handshake (valid & ready).
  - On handshake: clear valid, increment `sent_count_o`, advance channel (last wraps to first).
  - Then go to IDLE if either:
    - the count is reached (count ≠ 0 and the new sent count == count), or
    - a stop is pending.
  - Otherwise go to GEN.
  - `cfg_stop_i` in OFFER sets a sticky stop-pending flag; the offered descriptor is never withdrawn.

**Other rules**
- `done_o` pulses for one cycle on every transition into IDLE (completion or stop).
- `cfg_start_i` while busy is ignored.
- Sent counter wraps modulo 2^32 in infinite mode.

## Timing

- Reset values: `out_descriptor_valid_o`=0, `out_descriptor_data_o`=0, `busy_o`=0, `done_o`=0, `sent_count_o`=0, LFSR=seed, state IDLE.
- Start pulse in cycle N: `busy_o`=1 from N+1; the first GEN evaluation is in N+1.
- Latency: valid rises at the earliest in N+2 (1 GEN cycle); each rejection adds 1 cycle.
- Sustained throughput: at most one descriptor per 2 cycles (handshake cycle + ≥1 GEN cycle). This matches downstream acceptance (IDLE then BEGIN_TRANSFER).
- A reset mid-run aborts at once: valid drops asynchronously and nothing is held.
- LFSR: 16-bit Galois, taps 0xB400 (x^16+x^14+x^13+x^11+1). It steps only in GEN, so sequences are deterministic per run.

## Configuration

- Macro: `GENAXIS_DESCGEN_RANDOM_LEN_EN`.
- Defined: random length as described above.
- Undefined:
  - length = clamped `len_min`; `cfg_len_max_i` is ignored;
  - the LFSR is not instantiated;
  - GEN always accepts in exactly 1 cycle.

## Structure

- Shared package `genaxis_pkg`:
  - descriptor field offsets/widths (length [15:0], pause [47:16], channel [48+:ID_WIDTH]);
  - descriptor struct typedef;
  - `GENAXIS_LFSR_TAPS` constant;
  - FSM state enum.
- The downstream block reuses the field offsets.
- Sub-module `genaxis_lfsr16`: enable, load, seed, 16-bit value.

## Test plan

- **Fixed-length run**: count=3, min=max=64, pause=10, channels 2..3, ready=1 -> descriptors {2,10,64}, {3,10,64}, {2,10,64}; one `done_o` pulse; `sent_count_o`=3; `busy_o` low after.
- **Backpressure**: ready held 0 for 5 cycles during OFFER -> valid and data stable for all 5 cycles; exactly one handshake counted.
- **Random range**: random-length build, min=8, max=20, 2000 descriptors -> every length in [8,20], each of the 13 values seen; two runs with the same seed give identical sequences.
- **Stop**:
  - stop during OFFER with ready=0, then ready=1 -> that descriptor is delivered, then IDLE with `done_o`; `sent_count_o` includes it;
  - stop during GEN -> no new valid.
- **Clamps**:
  - min=0, max=0 -> length 1;
  - min=100, max=50 -> length 100;
  - first=5, last=3 -> channel always 5.
- **Reset mid-run**: `reset_n` low while valid=1 with count=0 -> all outputs 0 immediately; a new start restarts the LFSR from the seed.

Source files
------------

// File: rtl/genaxis_pkg.sv
// genaxis_pkg: definitions shared by the genaxis descriptor blocks.
//   - Descriptor field offsets/widths: length [15:0], pause [47:16],
//     channel [48 +: ID_WIDTH]. The downstream converter reuses these.
//   - genaxis_desc_lo_t: the fixed-width {pause, length} part of a descriptor.
//   - GENAXIS_LFSR_TAPS: Galois taps for x^16+x^14+x^13+x^11+1.
//   - genaxis_state_e: descriptor generator FSM states.
//   - genaxis_smear16(): OR-smear, giving the smallest 2^k-1 >= value.
package genaxis_pkg;

  localparam int unsigned GENAXIS_LEN_LSB   = 0;
  localparam int unsigned GENAXIS_LEN_W     = 16;
  localparam int unsigned GENAXIS_PAUSE_LSB = 16;
  localparam int unsigned GENAXIS_PAUSE_W   = 32;
  localparam int unsigned GENAXIS_CHAN_LSB  = 48;

  localparam logic [15:0] GENAXIS_LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [GENAXIS_PAUSE_W-1:0] pause;
    logic [GENAXIS_LEN_W-1:0]   length;
  } genaxis_desc_lo_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_OFFER = 2'd2
  } genaxis_state_e;

  function automatic logic [15:0] genaxis_smear16(input logic [15:0] v);
    logic [15:0] m;
    m = v;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m;
  endfunction

endpackage

// File: rtl/genaxis_lfsr16.sv
// genaxis_lfsr16: 16-bit Galois LFSR (taps GENAXIS_LFSR_TAPS, right shift).
//   SEED   : load value on reset and on load; 0 is replaced by 16'h0001.
//   clk    : clock
//   reset_n: asynchronous active-low reset (value <= seed)
//   enable : advance one step
//   load   : reload seed (has priority over enable)
//   value  : current LFSR state
module genaxis_lfsr16
  import genaxis_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        load,
  output logic [15:0] value
);

  // An all-zero Galois LFSR is stuck at zero forever.
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= SEED_SAFE;
    end else if (load) begin
      value <= SEED_SAFE;
    end else if (enable) begin
      value <= value[0] ? ((value >> 1) ^ GENAXIS_LFSR_TAPS) : (value >> 1);
    end
  end

endmodule

// File: rtl/genaxis_descriptor_gen.sv
// genaxis_descriptor_gen: generates {channel, pause, length} descriptors for
// genaxis_descriptor_to_axis.
//   Optional feature macro: GENAXIS_DESCGEN_RANDOM_LEN_EN
//     defined  : length drawn from an LFSR in [len_min, len_max] by rejection
//     undefined: length is the clamped len_min, no LFSR, GEN takes 1 cycle
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   cfg_start_i/cfg_stop_i  : run start/abort pulses
//   cfg_packet_count_i      : descriptors per run, 0 = run until stopped
//   cfg_len_min_i/max_i     : length bounds (bytes)
//   cfg_pause_i             : pause field (cycles)
//   cfg_channel_first/last_i: round-robin channel range
//   out_descriptor_*        : valid/ready descriptor stream
//   busy_o, done_o          : run in progress, one-cycle pulse on return to IDLE
//   sent_count_o            : descriptors accepted in the current/last run
module genaxis_descriptor_gen
  import genaxis_pkg::*;
#(
  parameter int unsigned ID_WIDTH  = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cfg_start_i,
  input  logic                               cfg_stop_i,
  input  logic [31:0]                        cfg_packet_count_i,
  input  logic [15:0]                        cfg_len_min_i,
  input  logic [15:0]                        cfg_len_max_i,
  input  logic [31:0]                        cfg_pause_i,
  input  logic [ID_WIDTH-1:0]                cfg_channel_first_i,
  input  logic [ID_WIDTH-1:0]                cfg_channel_last_i,
  output logic [GENAXIS_CHAN_LSB+ID_WIDTH-1:0] out_descriptor_data_o,
  output logic                               out_descriptor_valid_o,
  input  logic                               out_descriptor_ready_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [31:0]                        sent_count_o
);

  localparam int unsigned DW = GENAXIS_CHAN_LSB + ID_WIDTH;

  genaxis_state_e state_q, state_d;

  logic [31:0]         count_q;
  logic [31:0]         pause_q;
  logic [31:0]         sent_q;
  logic [15:0]         len_min_q;
  logic [ID_WIDTH-1:0] ch_first_q;
  logic [ID_WIDTH-1:0] ch_last_q;
  logic [ID_WIDTH-1:0] channel_q;
  logic [ID_WIDTH-1:0] channel_next;
  logic                stop_pend_q;
  logic                valid_q;
  logic                done_q;
  logic [DW-1:0]       data_q;

  logic                start_acc;
  logic                issue;
  logic                handshake;
  logic                cand_ok;
  logic [15:0]         len_sel;
  logic [15:0]         len_min_c;
  logic                count_hit;
  genaxis_desc_lo_t    desc_lo;

  assign len_min_c = (cfg_len_min_i == 16'h0000) ? 16'h0001 : cfg_len_min_i;

`ifdef GENAXIS_DESCGEN_RANDOM_LEN_EN
  logic [15:0] len_max_c;
  logic [15:0] range_c;
  logic [15:0] range_q;
  logic [15:0] mask_q;
  logic [15:0] lfsr_value;
  logic [15:0] cand;

  assign len_max_c = (cfg_len_max_i < len_min_c) ? len_min_c : cfg_len_max_i;
  assign range_c   = len_max_c - len_min_c;

  genaxis_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state_q == ST_GEN),
    .load    (start_acc),
    .value   (lfsr_value)
  );

  // Masking to the smallest 2^k-1 cover keeps the rejection rate below 1/2.
  assign cand    = lfsr_value & mask_q;
  assign cand_ok = (cand <= range_q);
  assign len_sel = len_min_q + cand;
`else
  logic        unused_len_max;
  logic [15:0] unused_seed;

  assign unused_len_max = ^cfg_len_max_i;
  assign unused_seed    = LFSR_SEED;
  assign cand_ok        = 1'b1;
  assign len_sel        = len_min_q;
`endif

  // With first > last, ch_last_q holds first, so the rotation stays on first.
  assign channel_next = (channel_q == ch_last_q) ? ch_first_q
                                                  : channel_q + ID_WIDTH'(1);
  assign count_hit    = (count_q != 32'd0) && ((sent_q + 32'd1) == count_q);

  always_comb begin
    desc_lo.pause  = pause_q;
    desc_lo.length = len_sel;
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    issue     = 1'b0;
    handshake = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i && !cfg_stop_i) begin
          start_acc = 1'b1;
          state_d   = ST_GEN;
        end
      end
      ST_GEN: begin
        if (cfg_stop_i) begin
          state_d = ST_IDLE;
        end else if (cand_ok) begin
          issue   = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (valid_q && out_descriptor_ready_i) begin
          handshake = 1'b1;
          if (count_hit || stop_pend_q || cfg_stop_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GEN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      pause_q     <= '0;
      sent_q      <= '0;
      len_min_q   <= '0;
      ch_first_q  <= '0;
      ch_last_q   <= '0;
      channel_q   <= '0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
`ifdef GENAXIS_DESCGEN_RANDOM_LEN_EN
      range_q     <= '0;
      mask_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= (state_q != ST_IDLE) && (state_d == ST_IDLE);

      if (start_acc) begin
        count_q     <= cfg_packet_count_i;
        pause_q     <= cfg_pause_i;
        len_min_q   <= len_min_c;
        ch_first_q  <= cfg_channel_first_i;
        ch_last_q   <= (cfg_channel_first_i > cfg_channel_last_i) ? cfg_channel_first_i
                                                                  : cfg_channel_last_i;
        channel_q   <= cfg_channel_first_i;
        sent_q      <= '0;
`ifdef GENAXIS_DESCGEN_RANDOM_LEN_EN
        range_q     <= range_c;
        mask_q      <= genaxis_smear16(range_c);
`endif
      end

      if (issue) begin
        data_q  <= {channel_q, desc_lo};
        valid_q <= 1'b1;
      end

      if (handshake) begin
        valid_q   <= 1'b0;
        sent_q    <= sent_q + 32'd1;
        channel_q <= channel_next;
      end

      // A stop seen while offering is remembered until the handshake.
      if (state_q == ST_OFFER && cfg_stop_i) begin
        stop_pend_q <= 1'b1;
      end
      if (state_d == ST_IDLE) begin
        stop_pend_q <= 1'b0;
      end
    end
  end

  assign out_descriptor_data_o  = data_q;
  assign out_descriptor_valid_o = valid_q;
  assign busy_o                 = (state_q != ST_IDLE);
  assign done_o                 = done_q;
  assign sent_count_o           = sent_q;

endmodule

// File: tb/tb_genaxis_descriptor_gen.sv
// tb_genaxis_descriptor_gen: randomized self-checking bench for
// genaxis_descriptor_gen against a queue-based descriptor model.
// Builds with or without GENAXIS_DESCGEN_RANDOM_LEN_EN.
module tb_genaxis_descriptor_gen;

  localparam int unsigned ID_WIDTH  = 10;
  localparam int unsigned DW        = 48 + ID_WIDTH;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                cfg_start_i = 1'b0;
  logic                cfg_stop_i = 1'b0;
  logic [31:0]         cfg_packet_count_i = '0;
  logic [15:0]         cfg_len_min_i = '0;
  logic [15:0]         cfg_len_max_i = '0;
  logic [31:0]         cfg_pause_i = '0;
  logic [ID_WIDTH-1:0] cfg_channel_first_i = '0;
  logic [ID_WIDTH-1:0] cfg_channel_last_i = '0;
  logic [DW-1:0]       out_descriptor_data_o;
  logic                out_descriptor_valid_o;
  logic                out_descriptor_ready_i = 1'b0;
  logic                busy_o;
  logic                done_o;
  logic [31:0]         sent_count_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int unsigned   done_cnt = 0;

  genaxis_descriptor_gen #(
    .ID_WIDTH  (ID_WIDTH),
    .LFSR_SEED (SEED)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .cfg_start_i            (cfg_start_i),
    .cfg_stop_i             (cfg_stop_i),
    .cfg_packet_count_i     (cfg_packet_count_i),
    .cfg_len_min_i          (cfg_len_min_i),
    .cfg_len_max_i          (cfg_len_max_i),
    .cfg_pause_i            (cfg_pause_i),
    .cfg_channel_first_i    (cfg_channel_first_i),
    .cfg_channel_last_i     (cfg_channel_last_i),
    .out_descriptor_data_o  (out_descriptor_data_o),
    .out_descriptor_valid_o (out_descriptor_valid_o),
    .out_descriptor_ready_i (out_descriptor_ready_i),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .sent_count_o           (sent_count_o)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+2, so at negedge valid/ready predict the next edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_descriptor_valid_o && out_descriptor_ready_i) got_q.push_back(out_descriptor_data_o);
      if (done_o) done_cnt++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run();
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_descriptor_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Expected descriptors of one run from the current cfg_* drive values.
  task automatic build_expected(input int n);
    int unsigned lmin, lmax, range, mask, nch, ch, len;
    logic [15:0] lfsr;
    logic [15:0] draw;
    exp_q.delete();
    lmin = (cfg_len_min_i == 0) ? 1 : int'(cfg_len_min_i);
    lmax = (int'(cfg_len_max_i) < lmin) ? lmin : int'(cfg_len_max_i);
    range = lmax - lmin;
    mask = 0;
    while (mask < range) mask = mask * 2 + 1;
    nch = (cfg_channel_first_i > cfg_channel_last_i) ? 1
        : int'(cfg_channel_last_i) - int'(cfg_channel_first_i) + 1;
    lfsr = (SEED == 16'h0000) ? 16'h0001 : SEED;
    for (int i = 0; i < n; i++) begin
      ch = int'(cfg_channel_first_i) + (i % nch);
`ifdef GENAXIS_DESCGEN_RANDOM_LEN_EN
      do begin
        draw = lfsr & mask[15:0];
        lfsr = lfsr_next(lfsr);
      end while (int'(draw) > range);
      len = lmin + int'(draw);
`else
      draw = lfsr;
      len = lmin;
`endif
      exp_q.push_back({ch[ID_WIDTH-1:0], cfg_pause_i, len[15:0]});
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (out_descriptor_valid_o !== 1'b0 || out_descriptor_data_o !== '0 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || sent_count_o !== 32'd0)
      begin errors++; $display("FAIL reset_state: valid=%b data=%h busy=%b done=%b sent=%0d, want all 0",
        out_descriptor_valid_o, out_descriptor_data_o, busy_o, done_o, sent_count_o); end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || out_descriptor_valid_o !== 1'b0)
      begin errors++; $display("FAIL post_reset_idle: busy=%b valid=%b, want 0 0", busy_o, out_descriptor_valid_o); end
  endtask

  task automatic test_fixed_run();
    bit ok;
    int unsigned d0;
    logic [DW-1:0] want [3];
    want[0] = {10'd2, 32'd10, 16'd64};
    want[1] = {10'd3, 32'd10, 16'd64};
    want[2] = {10'd2, 32'd10, 16'd64};
    cfg_packet_count_i = 32'd3; cfg_len_min_i = 16'd64; cfg_len_max_i = 16'd64;
    cfg_pause_i = 32'd10; cfg_channel_first_i = 10'd2; cfg_channel_last_i = 10'd3;
    out_descriptor_ready_i = 1'b1;
    got_q.delete(); d0 = done_cnt;
    start_run();
    checks++;
    if (busy_o !== 1'b1 || out_descriptor_valid_o !== 1'b0)
      begin errors++; $display("FAIL fixed_n_plus_1: busy=%b valid=%b, want 1 0", busy_o, out_descriptor_valid_o); end
    tick();
    checks++;
    if (out_descriptor_valid_o !== 1'b1)
      begin errors++; $display("FAIL fixed_latency: valid=%b at N+2, want 1", out_descriptor_valid_o); end
    wait_idle(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fixed_timeout: busy=%b, want 0 within 50 cycles", busy_o); end
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL fixed_count: got %0d descriptors, want 3", got_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q[i] !== want[i])
        begin errors++; $display("FAIL fixed_desc%0d: got %h want %h", i, got_q[i], want[i]); end
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL fixed_done: %0d pulses, want 1", done_cnt - d0); end
    checks++;
    if (sent_count_o !== 32'd3 || busy_o !== 1'b0)
      begin errors++; $display("FAIL fixed_final: sent=%0d busy=%b, want 3 0", sent_count_o, busy_o); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int unsigned d0, bad;
    logic [DW-1:0] held;
    cfg_packet_count_i = 32'd2; cfg_len_min_i = 16'd32; cfg_len_max_i = 16'd90;
    cfg_pause_i = $urandom; cfg_channel_first_i = 10'd7; cfg_channel_last_i = 10'd9;
    out_descriptor_ready_i = 1'b0;
    got_q.delete(); d0 = done_cnt;
    start_run();
    wait_valid(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_valid_timeout: valid=%b, want 1", out_descriptor_valid_o); end
    held = out_descriptor_data_o;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_descriptor_valid_o !== 1'b1 || out_descriptor_data_o !== held) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles, want 0", bad); end
    checks++;
    if (sent_count_o !== 32'd0) begin errors++; $display("FAIL bp_no_count: sent=%0d, want 0", sent_count_o); end
    out_descriptor_ready_i = 1'b1;
    tick();
    checks++;
    if (sent_count_o !== 32'd1 || out_descriptor_valid_o !== 1'b0)
      begin errors++; $display("FAIL bp_one_handshake: sent=%0d valid=%b, want 1 0", sent_count_o, out_descriptor_valid_o); end
    wait_idle(200, ok);
    checks++;
    if (!ok || sent_count_o !== 32'd2 || got_q.size() != 2 || done_cnt - d0 != 1)
      begin errors++; $display("FAIL bp_end: ok=%0d sent=%0d got=%0d done=%0d, want 1 2 2 1",
        ok, sent_count_o, got_q.size(), done_cnt - d0); end
    else begin
      checks++;
      if (got_q[0] !== held) begin errors++; $display("FAIL bp_first: got %h want %h", got_q[0], held); end
    end
  endtask

  task automatic test_random_cfg();
    bit ok;
    int unsigned d0, n;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      cfg_packet_count_i = n;
      cfg_len_min_i = 16'($urandom_range(0, 40));
      cfg_len_max_i = 16'($urandom_range(0, 60));
      cfg_pause_i = $urandom;
      cfg_channel_first_i = ID_WIDTH'($urandom_range(0, 7));
      cfg_channel_last_i = ID_WIDTH'($urandom_range(0, 7));
      build_expected(int'(n));
      got_q.delete(); d0 = done_cnt;
      start_run();
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        out_descriptor_ready_i = 1'($urandom_range(0, 1));
        tick();
        if (!busy_o) begin ok = 1'b1; break; end
      end
      out_descriptor_ready_i = 1'b1;
      tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL rnd%0d_timeout: busy=%b, want 0", r, busy_o); end
      checks++;
      if (got_q.size() != exp_q.size())
        begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", r, got_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i])
          begin errors++; $display("FAIL rnd%0d_desc%0d: got %h want %h", r, i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (sent_count_o !== n || done_cnt - d0 != 1)
        begin errors++; $display("FAIL rnd%0d_end: sent=%0d done=%0d, want %0d 1", r, sent_count_o, done_cnt - d0, n); end
    end
  endtask

  task automatic test_stop();
    bit ok;
    int unsigned d0, bad;
    // Start and stop together: nothing starts.
    cfg_packet_count_i = 32'd0; cfg_len_min_i = 16'd16; cfg_len_max_i = 16'd16;
    cfg_channel_first_i = 10'd1; cfg_channel_last_i = 10'd4;
    cfg_start_i = 1'b1; cfg_stop_i = 1'b1;
    tick();
    cfg_start_i = 1'b0; cfg_stop_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL start_stop_same: busy=%b, want 0", busy_o); end

    // Stop during GEN: back to IDLE, no descriptor.
    out_descriptor_ready_i = 1'b1;
    got_q.delete(); d0 = done_cnt;
    start_run();
    cfg_stop_i = 1'b1;
    tick();
    cfg_stop_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || out_descriptor_valid_o !== 1'b0 || done_o !== 1'b1)
      begin errors++; $display("FAIL stop_gen: busy=%b valid=%b done=%b, want 0 0 1", busy_o, out_descriptor_valid_o, done_o); end
    repeat (4) tick();
    checks++;
    if (got_q.size() != 0 || sent_count_o !== 32'd0 || done_cnt - d0 != 1)
      begin errors++; $display("FAIL stop_gen_quiet: got=%0d sent=%0d done=%0d, want 0 0 1",
        got_q.size(), sent_count_o, done_cnt - d0); end

    // Stop during OFFER with ready low: the descriptor is still delivered.
    out_descriptor_ready_i = 1'b0;
    got_q.delete(); d0 = done_cnt;
    start_run();
    wait_valid(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stop_offer_valid: valid=%b, want 1", out_descriptor_valid_o); end
    cfg_stop_i = 1'b1;
    tick();
    cfg_stop_i = 1'b0;
    bad = 0;
    repeat (3) begin
      if (out_descriptor_valid_o !== 1'b1 || busy_o !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stop_offer_hold: %0d cycles withdrawn, want 0", bad); end
    out_descriptor_ready_i = 1'b1;
    wait_idle(20, ok);
    checks++;
    if (!ok || got_q.size() != 1 || sent_count_o !== 32'd1 || done_cnt - d0 != 1 || out_descriptor_valid_o !== 1'b0)
      begin errors++; $display("FAIL stop_offer_end: ok=%0d got=%0d sent=%0d done=%0d valid=%b, want 1 1 1 1 0",
        ok, got_q.size(), sent_count_o, done_cnt - d0, out_descriptor_valid_o); end
  endtask

  task automatic test_clamps();
    bit ok;
    int unsigned bad;
    logic [DW-1:0] d;
    out_descriptor_ready_i = 1'b1;
    cfg_packet_count_i = 32'd3; cfg_pause_i = 32'd5;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin cfg_len_min_i = 16'd0;   cfg_len_max_i = 16'd0;  cfg_channel_first_i = 10'd0; cfg_channel_last_i = 10'd1; end
        1: begin cfg_len_min_i = 16'd100; cfg_len_max_i = 16'd50; cfg_channel_first_i = 10'd0; cfg_channel_last_i = 10'd1; end
        default: begin cfg_len_min_i = 16'd9; cfg_len_max_i = 16'd9; cfg_channel_first_i = 10'd5; cfg_channel_last_i = 10'd3; end
      endcase
      got_q.delete();
      start_run();
      wait_idle(50, ok);
      bad = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        d = got_q[i];
        if (k == 0 && d[15:0] !== 16'd1) bad++;
        if (k == 1 && d[15:0] !== 16'd100) bad++;
        if (k == 2 && d[57:48] !== 10'd5) bad++;
      end
      checks++;
      if (!ok || got_q.size() != 3 || bad != 0)
        begin errors++; $display("FAIL clamp%0d: ok=%0d got=%0d bad=%0d, want 1 3 0", k, ok, got_q.size(), bad); end
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    cfg_packet_count_i = 32'd0; cfg_len_min_i = 16'd3; cfg_len_max_i = 16'd300;
    cfg_pause_i = 32'd77; cfg_channel_first_i = 10'd0; cfg_channel_last_i = 10'd2;
    out_descriptor_ready_i = 1'b0;
    got_q.delete();
    start_run();
    wait_valid(100, ok);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || out_descriptor_valid_o !== 1'b0 || out_descriptor_data_o !== '0 || busy_o !== 1'b0 ||
        sent_count_o !== 32'd0 || done_o !== 1'b0)
      begin errors++; $display("FAIL reset_midrun: ok=%0d valid=%b data=%h busy=%b sent=%0d done=%b, want 1 and all 0",
        ok, out_descriptor_valid_o, out_descriptor_data_o, busy_o, sent_count_o, done_o); end
    tick();
    reset_n = 1'b1;
    tick();
    cfg_packet_count_i = 32'd5;
    build_expected(5);
    got_q.delete();
    start_run();
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_descriptor_ready_i = 1'($urandom_range(0, 1));
      tick();
      if (!busy_o) begin ok = 1'b1; break; end
    end
    out_descriptor_ready_i = 1'b1;
    tick();
    checks++;
    if (!ok || got_q.size() != 5)
      begin errors++; $display("FAIL restart_count: ok=%0d got=%0d, want 1 5", ok, got_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i])
        begin errors++; $display("FAIL restart_desc%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

`ifdef GENAXIS_DESCGEN_RANDOM_LEN_EN
  task automatic test_random_range();
    bit ok;
    int unsigned bad, mism, missing;
    bit seen [21];
    logic [DW-1:0] first_run[$];
    logic [15:0] len;
    cfg_packet_count_i = 32'd2000; cfg_len_min_i = 16'd8; cfg_len_max_i = 16'd20;
    cfg_pause_i = 32'd3; cfg_channel_first_i = 10'd0; cfg_channel_last_i = 10'd3;
    out_descriptor_ready_i = 1'b1;
    for (int i = 0; i < 21; i++) seen[i] = 1'b0;
    build_expected(2000);
    got_q.delete();
    start_run();
    wait_idle(20000, ok);
    checks++;
    if (!ok || got_q.size() != 2000)
      begin errors++; $display("FAIL range_run: ok=%0d got=%0d, want 1 2000", ok, got_q.size()); end
    bad = 0; mism = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      len = got_q[i][15:0];
      if (len < 16'd8 || len > 16'd20) bad++;
      else seen[len] = 1'b1;
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) mism++;
    end
    missing = 0;
    for (int v = 8; v <= 20; v++) if (!seen[v]) missing++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL range_bounds: %0d out of range, want 0", bad); end
    checks++;
    if (missing != 0) begin errors++; $display("FAIL range_cover: %0d values unseen, want 0", missing); end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL range_model: %0d mismatches, want 0", mism); end
    first_run = got_q;
    got_q.delete();
    start_run();
    wait_idle(20000, ok);
    mism = 0;
    for (int i = 0; i < first_run.size(); i++)
      if (i >= got_q.size() || got_q[i] !== first_run[i]) mism++;
    checks++;
    if (!ok || got_q.size() != first_run.size() || mism != 0)
      begin errors++; $display("FAIL range_repeat: ok=%0d got=%0d diffs=%0d, want 1 %0d 0",
        ok, got_q.size(), mism, first_run.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_run();
    test_backpressure();
    test_random_cfg();
    test_stop();
    test_clamps();
    test_reset_midrun();
`ifdef GENAXIS_DESCGEN_RANDOM_LEN_EN
    test_random_range();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
